// File: rtl/ntsc_clock_enables_pkg.sv
// NTSC timing constants shared by the clock-enable, video and CPU blocks.
// Also carries the raster position type and its wrapping increment.
package ntsc_clock_enables_pkg;

  localparam int unsigned NTSC_CPU_DIV         = 12;
  localparam int unsigned NTSC_PPU_DIV         = 4;
  localparam int unsigned NTSC_DOTS_PER_LINE   = 341;
  localparam int unsigned NTSC_LINES_PER_FRAME = 262;
  localparam int unsigned NTSC_H_VISIBLE       = 256;
  localparam int unsigned NTSC_V_VISIBLE       = 240;

  localparam int unsigned POS_W = 9;
  typedef logic [POS_W-1:0] pos_t;

  // Increment a raster position, returning to 0 after modulus-1.
  function automatic pos_t wrap_inc(input pos_t v, input int unsigned modulus);
    return (v == pos_t'(modulus - 1)) ? '0 : v + 1'b1;
  endfunction

endpackage

// File: rtl/ntsc_clock_enables_ce_divider.sv
// Modulo-N counter advanced by an input strobe; hit flags the strobe that finds the count at 0.
// The caller registers hit to form the clock-enable pulse.
module ce_divider #(
  parameter int unsigned N = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic strobe,
  output logic hit
);

  localparam int unsigned W = (N > 1) ? $clog2(N) : 1;
  localparam logic [W-1:0] LAST = W'(N - 1);

  logic [W-1:0] cnt;

  assign hit = strobe & (cnt == '0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (strobe) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/ntsc_clock_enables.sv
// Turns the DDS square wave into master/CPU/PPU clock enables and tracks the NTSC raster position.
// Every output is registered; blank flags come from the next-state position so they track dot_x/line_y.
module ntsc_clock_enables
  import ntsc_clock_enables_pkg::*;
#(
  parameter int unsigned CPU_DIV         = NTSC_CPU_DIV,
  parameter int unsigned PPU_DIV         = NTSC_PPU_DIV,
  parameter int unsigned DOTS_PER_LINE   = NTSC_DOTS_PER_LINE,
  parameter int unsigned LINES_PER_FRAME = NTSC_LINES_PER_FRAME,
  parameter int unsigned H_VISIBLE       = NTSC_H_VISIBLE,
  parameter int unsigned V_VISIBLE       = NTSC_V_VISIBLE
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic tick_in,
  output logic master_ce,
  output logic cpu_ce,
  output logic ppu_ce,
  output pos_t dot_x,
  output pos_t line_y,
  output logic hblank,
  output logic vblank,
  output logic frame_start
);

  localparam pos_t LAST_DOT  = pos_t'(DOTS_PER_LINE - 1);
  localparam pos_t LAST_LINE = pos_t'(LINES_PER_FRAME - 1);
  localparam pos_t H_LIM     = pos_t'(H_VISIBLE);
  localparam pos_t V_LIM     = pos_t'(V_VISIBLE);

  logic tick_q;
  logic rise;
  logic cpu_hit;
  logic ppu_hit;
  pos_t dot_d;
  pos_t line_d;
  logic frame_start_d;

  // tick_q tracks tick_in even while disabled, so re-enabling mid-high waits for a fresh edge.
  assign rise = tick_in & ~tick_q & enable;

  ce_divider #(
    .N(CPU_DIV)
  ) u_cpu_div (
    .clk    (clk),
    .reset_n(reset_n),
    .strobe (rise),
    .hit    (cpu_hit)
  );

  ce_divider #(
    .N(PPU_DIV)
  ) u_ppu_div (
    .clk    (clk),
    .reset_n(reset_n),
    .strobe (rise),
    .hit    (ppu_hit)
  );

  always_comb begin
    dot_d         = dot_x;
    line_d        = line_y;
    frame_start_d = 1'b0;
    if (ppu_hit) begin
      dot_d = wrap_inc(dot_x, DOTS_PER_LINE);
      if (dot_x == LAST_DOT) begin
        line_d        = wrap_inc(line_y, LINES_PER_FRAME);
        frame_start_d = (line_y == LAST_LINE);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q      <= 1'b0;
      master_ce   <= 1'b0;
      cpu_ce      <= 1'b0;
      ppu_ce      <= 1'b0;
      dot_x       <= '0;
      line_y      <= '0;
      hblank      <= 1'b0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      tick_q      <= tick_in;
      master_ce   <= rise;
      cpu_ce      <= cpu_hit;
      ppu_ce      <= ppu_hit;
      dot_x       <= dot_d;
      line_y      <= line_d;
      hblank      <= (dot_d >= H_LIM);
      vblank      <= (line_d >= V_LIM);
      frame_start <= frame_start_d;
    end
  end

endmodule
